lfsr_mem_tester: RTL and testbench
==================================

Name: lfsr_mem_tester

Overview:
- Built-in memory traffic checker that sits directly downstream of the 16-bit LFSR pattern generator and upstream of the memory controller request port.
- On START it issues DEPTH write requests carrying LFSR words to consecutive addresses, then DEPTH reads of the same addresses.
- It compares each read response against an internal scoreboard of the written words and reports pass/fail, an error count, and the first failing address.

Parameters:
- DEPTH, 16, number of words per test pass; power of two, 2..256.
- ADDR_W, 8, memory address width.
- DATA_W, 16, data width; equals the LFSR output width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that starts a test; honoured only in IDLE or DONE.
- BASE_ADDR  in  ADDR_W  first test address; sampled on an accepted START.
- LFSR_IN  in  DATA_W  free-running pseudo-random word from the LFSR stage.
- REQ_VALID  out  1  request valid.
- REQ_READY  in  1  controller accepts the request when REQ_VALID and REQ_READY are both high.
- REQ_WE  out  1  1 = write, 0 = read.
- REQ_ADDR  out  ADDR_W  request address.
- REQ_WDATA  out  DATA_W  write data.
- RD_VALID  in  1  read response valid, one cycle per response, returned in request order.
- RD_DATA  in  DATA_W  read response data.
- BUSY  out  1  high in WRITE, READ and DRAIN.
- DONE  out  1  high in the DONE state.
- PASS  out  1  valid while DONE is high; 1 if ERR_CNT == 0.
- ERR_CNT  out  8  mismatch count, saturates at 255.
- FIRST_ERR_ADDR  out  ADDR_W  address of the first mismatch; 0 if no mismatch.

Behaviour:
- Reset values: all outputs 0, state IDLE, all indices 0. Scoreboard contents are don't-care.
- States:
  - IDLE: waits for START.
  - WRITE: issues the DEPTH writes.
  - READ: issues the DEPTH reads.
  - DRAIN: waits for outstanding read responses.
  - DONE: holds results.
- START accepted (IDLE or DONE), on the same edge:
  - Clear ERR_CNT, FIRST_ERR_ADDR, PASS and the indices.
  - Latch BASE_ADDR.
  - Register REQ_WDATA <= LFSR_IN.
  - Set REQ_VALID=1, REQ_WE=1, REQ_ADDR=BASE_ADDR.
  - Go to WRITE.
- START in WRITE, READ or DRAIN is ignored.
- Requests are registered. REQ_ADDR, REQ_WE and REQ_WDATA are stable while REQ_VALID=1 and REQ_READY=0. REQ_VALID never drops without a handshake.
- WRITE, on each handshake with write index w:
  - scoreboard[w] <= REQ_WDATA.
  - If w < DEPTH-1: REQ_ADDR <= base+w+1 and REQ_WDATA <= current LFSR_IN. REQ_VALID stays high, so back-to-back writes run at 1 per cycle.
  - If w = DEPTH-1: REQ_WE <= 0, REQ_ADDR <= base, go to READ. REQ_VALID stays high, so the first read is presented on the next cycle.
- READ, on each handshake with read index r:
  - If r < DEPTH-1: REQ_ADDR <= base+r+1.
  - If r = DEPTH-1: REQ_VALID <= 0, go to DRAIN.
- Address arithmetic is modulo 2^ADDR_W; base+i wraps.
- Response checking is active in READ and DRAIN. On RD_VALID with response index c:
  - Compare RD_DATA with scoreboard[c].
  - On mismatch: ERR_CNT increments, saturating at 255. If this is the first mismatch, FIRST_ERR_ADDR <= base+c.
  - c increments.
- A response may arrive in the same cycle as a read handshake. Both are processed and the indices are independent.
- RD_VALID in IDLE, WRITE or DONE is ignored: no count, no compare.
- When c reaches DEPTH, go to DONE: DONE=1, BUSY=0, PASS=(ERR_CNT==0) using the final count, including the last response. This holds whether the last response arrives in READ or in DRAIN.
- DONE holds its results until the next START or reset. There is no timeout.
- RSTN asserted mid-test returns immediately to IDLE with reset values. Any request in flight is abandoned.

Test Plan:
- Clean pass, DEPTH=16, BASE_ADDR=0x20:
  - Stimulus: controller model with REQ_READY=1 and 2-cycle read latency echoing memory; START.
  - Required: 16 writes to 0x20..0x2F at 1 per cycle, then 16 reads; DONE=1, PASS=1, ERR_CNT=0.
- Single corruption:
  - Stimulus: model flips bit 0 of the response for address 0x25.
  - Required: ERR_CNT=1, FIRST_ERR_ADDR=0x25, PASS=0.
- Backpressure:
  - Stimulus: REQ_READY toggles 1,0,0,1 repeatedly; LFSR_IN changes every cycle.
  - Required: REQ_ADDR and REQ_WDATA are stable during stalls, and each written word equals LFSR_IN at the load edge.
- Address wrap, BASE_ADDR=0xF8:
  - Required: addresses run 0xF8..0xFF then 0x00..0x07; PASS=1.
- Saturation and restart:
  - Stimulus: DEPTH=256 with all responses inverted.
  - Required: ERR_CNT=255, FIRST_ERR_ADDR=base. A second START from DONE with a clean model gives ERR_CNT=0, PASS=1.
- Reset mid-test:
  - Stimulus: RSTN low during READ.
  - Required: all outputs 0 asynchronously; a later START runs a complete clean pass.

Source files
------------

// File: rtl/lfsr_mem_tester_if.sv
// Request/response bus between the memory traffic checker (master) and the
// memory controller request port (slave).
interface lfsr_mem_tester_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/lfsr_mem_tester.sv
// Built-in memory checker: writes DEPTH LFSR words to consecutive addresses,
// reads them back in order and scores the responses against a local copy.
module lfsr_mem_tester #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [DATA_W-1:0]   lfsr_i,
  lfsr_mem_tester_if.master   mem,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [7:0]          err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]    w_idx_q, w_idx_d;
  logic [IDX_W-1:0]    r_idx_q, r_idx_d;
  logic [IDX_W-1:0]    c_idx_q, c_idx_d;
  logic                req_valid_q, req_valid_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic                pass_q, pass_d;
  logic                sb_we;
  logic [DATA_W-1:0]   sb_q [DEPTH];

  logic handshake;
  assign handshake = req_valid_q & mem.req_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    base_d      = base_q;
    w_idx_d     = w_idx_q;
    r_idx_d     = r_idx_q;
    c_idx_d     = c_idx_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    sb_we       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_idx_d     = '0;
          r_idx_d     = '0;
          c_idx_d     = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          base_d      = base_addr_i;
          req_valid_d = 1'b1;
          req_we_d    = 1'b1;
          req_addr_d  = base_addr_i;
          req_wdata_d = lfsr_i;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (handshake) begin
          sb_we = 1'b1;
          if (w_idx_q == LAST_IDX) begin
            // First read is presented on the very next cycle.
            req_we_d   = 1'b0;
            req_addr_d = base_q;
            state_d    = S_READ;
          end else begin
            w_idx_d     = w_idx_q + IDX_W'(1);
            req_addr_d  = base_q + ADDR_W'(w_idx_q) + ADDR_W'(1);
            req_wdata_d = lfsr_i;
          end
        end
      end
      S_READ: begin
        if (handshake) begin
          if (r_idx_q == LAST_IDX) begin
            req_valid_d = 1'b0;
            state_d     = S_DRAIN;
          end else begin
            r_idx_d    = r_idx_q + IDX_W'(1);
            req_addr_d = base_q + ADDR_W'(r_idx_q) + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Response scoring runs alongside read issue; the two indices are independent.
    if ((state_q == S_READ || state_q == S_DRAIN) && mem.rd_valid) begin
      if (mem.rd_data != sb_q[c_idx_q]) begin
        if (err_cnt_q == 8'd0) first_err_d = base_q + ADDR_W'(c_idx_q);
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      if (c_idx_q == LAST_IDX) begin
        req_valid_d = 1'b0;
        pass_d      = (err_cnt_d == 8'd0);
        state_d     = S_DONE;
      end else begin
        c_idx_d = c_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      w_idx_q     <= '0;
      r_idx_q     <= '0;
      c_idx_q     <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      w_idx_q     <= w_idx_d;
      r_idx_q     <= r_idx_d;
      c_idx_q     <= c_idx_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  // NOTE: the scoreboard has no reset; each entry is written before it is read in every pass.
  always_ff @(posedge clk) begin
    if (sb_we) sb_q[w_idx_q] <= req_wdata_q;
  end

  assign mem.req_valid    = req_valid_q;
  assign mem.req_we       = req_we_q;
  assign mem.req_addr     = req_addr_q;
  assign mem.req_wdata    = req_wdata_q;
  assign busy_o           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_lfsr_mem_tester.sv
// Bench for lfsr_mem_tester: a memory/controller model with 2-cycle read
// latency, fault injection and backpressure, driving a DEPTH=16 and a DEPTH=256 instance.
module tb_lfsr_mem_tester;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [15:0] lfsr = '0;
  logic        sel = 1'b0;
  int          depth = 16;
  bit          corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = '0;
  bit          invert_all = 1'b0;
  bit          bp_mode = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_rd_valid = 1'b0;
  logic [15:0] m_rd_data = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lfsr_mem_tester_if #(.ADDR_W(8), .DATA_W(16)) bus16 ();
  lfsr_mem_tester_if #(.ADDR_W(8), .DATA_W(16)) bus256 ();

  assign bus16.req_ready  = m_ready;
  assign bus16.rd_valid   = m_rd_valid;
  assign bus16.rd_data    = m_rd_data;
  assign bus256.req_ready = m_ready;
  assign bus256.rd_valid  = m_rd_valid;
  assign bus256.rd_data   = m_rd_data;

  logic start16, start256;
  assign start16  = start & ~sel;
  assign start256 = start & sel;

  logic       busy16, done16, pass16, busy256, done256, pass256;
  logic [7:0] err16, first16, err256, first256;

  lfsr_mem_tester #(.DEPTH(16), .ADDR_W(8), .DATA_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(start16), .base_addr_i(base_addr), .lfsr_i(lfsr),
    .mem(bus16.master), .busy_o(busy16), .done_o(done16), .pass_o(pass16),
    .err_cnt_o(err16), .first_err_addr_o(first16)
  );

  lfsr_mem_tester #(.DEPTH(256), .ADDR_W(8), .DATA_W(16)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start_i(start256), .base_addr_i(base_addr), .lfsr_i(lfsr),
    .mem(bus256.master), .busy_o(busy256), .done_o(done256), .pass_o(pass256),
    .err_cnt_o(err256), .first_err_addr_o(first256)
  );

  // View of whichever instance is under test.
  logic        m_valid, m_we, m_busy, m_done, m_pass;
  logic [7:0]  m_addr, m_err, m_first;
  logic [15:0] m_wdata;
  always_comb begin
    if (sel) begin
      m_valid = bus256.req_valid; m_we = bus256.req_we; m_addr = bus256.req_addr;
      m_wdata = bus256.req_wdata; m_busy = busy256; m_done = done256; m_pass = pass256;
      m_err = err256; m_first = first256;
    end else begin
      m_valid = bus16.req_valid; m_we = bus16.req_we; m_addr = bus16.req_addr;
      m_wdata = bus16.req_wdata; m_busy = busy16; m_done = done16; m_pass = pass16;
      m_err = err16; m_first = first16;
    end
  end

  // Reference model state: memory contents, expected written words and observed traffic.
  logic [15:0] mem_model [256];
  logic [15:0] exp_words [$];
  logic [7:0]  wr_addr_log [$];
  logic [15:0] wr_data_log [$];
  logic [7:0]  rd_addr_log [$];
  int          n_resp = 0, exp_err = 0, stall_viol = 0, cyc = 0;
  int          wr_first_cyc = 0, wr_last_cyc = 0, rd_first_cyc = 0;
  logic [7:0]  exp_first = '0, act_base = '0;
  logic [16:0] pipe1 = '0, pipe2 = '0;
  bit          prev_stall = 1'b0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  always @(negedge clk) begin : controller_model
    logic [15:0] d;
    logic [16:0] incoming;
    if (!rst_n) begin
      pipe1 = '0; pipe2 = '0; m_rd_valid = 1'b0; prev_stall = 1'b0; m_ready = 1'b1;
    end else begin
      cyc++;
      lfsr    = 16'($urandom);
      m_ready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (prev_stall && (!m_valid || m_we !== prev_we || m_addr !== prev_addr || m_wdata !== prev_wdata))
        stall_viol++;
      if (start && !m_busy) begin
        exp_words.delete(); wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
        exp_words.push_back(lfsr);
        n_resp = 0; exp_err = 0; exp_first = '0; act_base = base_addr; stall_viol = 0;
      end
      incoming = '0;
      if (m_valid && m_ready) begin
        if (m_we) begin
          if (wr_addr_log.size() == 0) wr_first_cyc = cyc;
          wr_last_cyc = cyc;
          wr_addr_log.push_back(m_addr);
          wr_data_log.push_back(m_wdata);
          mem_model[m_addr] = m_wdata;
          if (wr_addr_log.size() < depth) exp_words.push_back(lfsr);
        end else begin
          if (rd_addr_log.size() == 0) rd_first_cyc = cyc;
          rd_addr_log.push_back(m_addr);
          d = mem_model[m_addr];
          if (invert_all) d = ~d;
          if (corrupt_en && m_addr == corrupt_addr) d[0] = ~d[0];
          incoming = {1'b1, d};
        end
      end
      m_rd_valid = pipe2[16];
      m_rd_data  = pipe2[15:0];
      pipe2 = pipe1;
      pipe1 = incoming;
      if (m_rd_valid) begin
        if (n_resp < exp_words.size() && m_rd_data !== exp_words[n_resp]) begin
          if (exp_err == 0) exp_first = act_base + 8'(n_resp);
          if (exp_err < 255) exp_err++;
        end
        n_resp++;
      end
      prev_stall = m_valid && !m_ready;
      prev_we    = m_we;
      prev_addr  = m_addr;
      prev_wdata = m_wdata;
    end
  end

  task automatic launch(input logic [7:0] b);
    @(posedge clk); #1;
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!m_done && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, m_done, n);
    end
  endtask

  task automatic verify_results(input string name);
    int bad;
    checks++;
    if (wr_addr_log.size() != depth || rd_addr_log.size() != depth) begin
      errors++;
      $display("FAIL %s counts: writes=%0d reads=%0d, required %0d each",
               name, wr_addr_log.size(), rd_addr_log.size(), depth);
    end
    bad = 0;
    foreach (wr_addr_log[i]) if (wr_addr_log[i] !== act_base + 8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s write addresses: %0d wrong, required base+i from %h", name, bad, act_base);
    end
    bad = 0;
    foreach (wr_data_log[i]) if (i >= exp_words.size() || wr_data_log[i] !== exp_words[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s write data: %0d words differ from LFSR at load edge", name, bad);
    end
    bad = 0;
    foreach (rd_addr_log[i]) if (rd_addr_log[i] !== act_base + 8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s read addresses: %0d wrong, required base+i from %h", name, bad, act_base);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL %s stall stability: %0d violations, required 0", name, stall_viol);
    end
    checks++;
    if (m_err !== 8'(exp_err)) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d required %0d", name, m_err, exp_err);
    end
    checks++;
    if (m_first !== exp_first) begin
      errors++;
      $display("FAIL %s first_err_addr: got %h required %h", name, m_first, exp_first);
    end
    checks++;
    if (m_pass !== (exp_err == 0) || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pass/busy: got %b/%b required %b/0", name, m_pass, m_busy, exp_err == 0);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus16.req_valid, bus16.req_we, bus16.req_addr, bus16.req_wdata, busy16, done16, pass16, err16, first16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs during reset, required all 0");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({m_valid, m_busy, m_done, m_pass, m_err, m_first} !== '0) begin
      errors++;
      $display("FAIL reset_idle: valid=%b busy=%b done=%b pass=%b err=%0d first=%h, required all 0",
               m_valid, m_busy, m_done, m_pass, m_err, m_first);
    end
  endtask

  task automatic test_clean_pass();
    sel = 1'b0; depth = 16; bp_mode = 1'b0; corrupt_en = 1'b0; invert_all = 1'b0;
    launch(8'h20);
    wait_done("clean");
    verify_results("clean");
    checks++;
    if (m_err !== 8'd0 || m_pass !== 1'b1) begin
      errors++;
      $display("FAIL clean result: err=%0d pass=%b, required 0/1", m_err, m_pass);
    end
    checks++;
    if (wr_last_cyc - wr_first_cyc != 15 || rd_first_cyc != wr_last_cyc + 1) begin
      errors++;
      $display("FAIL clean rate: write span=%0d first read gap=%0d, required 15 and 1",
               wr_last_cyc - wr_first_cyc, rd_first_cyc - wr_last_cyc);
    end
  endtask

  task automatic test_single_corruption();
    corrupt_en = 1'b1; corrupt_addr = 8'h25;
    launch(8'h20);
    wait_done("corrupt");
    verify_results("corrupt");
    checks++;
    if (m_err !== 8'd1 || m_first !== 8'h25 || m_pass !== 1'b0) begin
      errors++;
      $display("FAIL corrupt result: err=%0d first=%h pass=%b, required 1/25/0", m_err, m_first, m_pass);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_backpressure();
    bp_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      launch(8'($urandom));
      wait_done("backpressure");
      verify_results("backpressure");
    end
    bp_mode = 1'b0;
  endtask

  task automatic test_addr_wrap();
    launch(8'hF8);
    wait_done("wrap");
    verify_results("wrap");
    checks++;
    if (wr_addr_log.size() != 16 || wr_addr_log[7] !== 8'hFF || wr_addr_log[8] !== 8'h00 || m_pass !== 1'b1) begin
      errors++;
      $display("FAIL wrap boundary: writes=%0d pass=%b, required FF then 00 and pass=1",
               wr_addr_log.size(), m_pass);
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] b;
    b = 8'($urandom);
    launch(b);
    repeat (4) @(posedge clk); #1;
    base_addr = b + 8'h40;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done("ignored_start");
    verify_results("ignored_start");
  endtask

  task automatic test_saturation_restart();
    logic [7:0] b;
    b = 8'($urandom);
    sel = 1'b1; depth = 256; invert_all = 1'b1;
    launch(b);
    wait_done("saturate");
    verify_results("saturate");
    checks++;
    if (m_err !== 8'd255 || m_first !== b || m_pass !== 1'b0) begin
      errors++;
      $display("FAIL saturate result: err=%0d first=%h pass=%b, required 255/%h/0", m_err, m_first, m_pass, b);
    end
    invert_all = 1'b0;
    launch(8'($urandom));
    wait_done("restart");
    verify_results("restart");
    checks++;
    if (m_err !== 8'd0 || m_pass !== 1'b1) begin
      errors++;
      $display("FAIL restart result: err=%0d pass=%b, required 0/1", m_err, m_pass);
    end
    sel = 1'b0; depth = 16;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    launch(8'h60);
    while (rd_addr_log.size() < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_busy !== 1'b1 || m_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid setup: busy=%b we=%b, required READ phase", m_busy, m_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_we, m_addr, m_wdata, m_busy, m_done, m_pass, m_err, m_first} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: valid=%b addr=%h busy=%b err=%0d, required all 0",
               m_valid, m_addr, m_busy, m_err);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    launch(8'($urandom));
    wait_done("after_reset");
    verify_results("after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_pass();
    test_single_corruption();
    test_backpressure();
    test_addr_wrap();
    test_ignored_start();
    test_saturation_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
